// File: rtl/clk_mon_pkg.sv
// Shared types and default timing constants for the clock monitor and the
// clkdiv bench that drives it.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      MEASURE   = 2'd2,
      LOCKED    = 2'd3
   } state_t;

   localparam int DEF_EXP_PERIOD = 10;
   localparam int DEF_TOL        = 0;
   localparam int DEF_LOCK_CNT   = 4;
   localparam int DEF_TIMEOUT    = 1000;

endpackage

// File: rtl/clk_mon_sync_edge.sv
// Synchronizer chain (STAGES flops, 0 = bypass) plus rising-edge detector.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s,
   output logic re
);

   logic s_d_reg;

   generate
      if (STAGES == 0) begin : g_bypass
         assign s = d;
      end else begin : g_sync
         logic [STAGES-1:0] sync_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_reg <= '0;
            end else begin
               sync_reg[0] <= d;
               for (int i = 1; i < STAGES; i++) begin
                  sync_reg[i] <= sync_reg[i-1];
               end
            end
         end
         assign s = sync_reg[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_d_reg <= 1'b0;
      end else begin
         s_d_reg <= s;
      end
   end

   assign re = s & ~s_d_reg;

endmodule

// File: rtl/clk_mon.sv
// Measures period and high time of i_mon in i_clk cycles, checks the period
// against EXP_PERIOD +/- TOL, and reports lock, sticky error and timeout.
module clk_mon
   import clk_mon_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int EXP_PERIOD  = DEF_EXP_PERIOD,
   parameter int TOL         = DEF_TOL,
   parameter int LOCK_CNT    = DEF_LOCK_CNT,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_mon,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic             o_valid,
   output logic             o_lock,
   output logic             o_err,
   output logic             o_timeout
);

   localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   EXP_X   = (CNT_W+1)'(EXP_PERIOD);
   localparam logic [CNT_W:0]   TOL_X   = (CNT_W+1)'(TOL);
   localparam logic [GW-1:0]    LOCK_X  = GW'(LOCK_CNT);

   logic s, re;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk (i_clk),
      .rst (i_rst),
      .d   (i_mon),
      .s   (s),
      .re  (re)
   );

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg, hcnt_reg;
   logic [GW-1:0]    good_reg;

   logic [CNT_W-1:0] cnt_next, hcnt_next;
   logic [GW-1:0]    good_next;
   logic [CNT_W:0]   cnt_x, diff;
   logic             in_tol, to_hit;

   always_comb begin
      cnt_next  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
      hcnt_next = (hcnt_reg == CNT_MAX) ? hcnt_reg : hcnt_reg + CNT_W'(s);
      good_next = (good_reg == LOCK_X) ? good_reg : good_reg + 1'b1;
      cnt_x     = {1'b0, cnt_reg};
      diff      = (cnt_x >= EXP_X) ? (cnt_x - EXP_X) : (EXP_X - cnt_x);
      // A saturated counter means the true period is unknown: never good.
      in_tol    = (diff <= TOL_X) && (cnt_reg != CNT_MAX);
      to_hit    = !re && (cnt_reg == TO_VAL);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         hcnt_reg  <= '0;
         good_reg  <= '0;
         o_period  <= '0;
         o_high    <= '0;
         o_valid   <= 1'b0;
         o_lock    <= 1'b0;
         o_err     <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         // Later assignments below override the clear, so a new event wins.
         if (i_clr) begin
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
         end
         if (!i_en) begin
            state_reg <= IDLE;
            o_lock    <= 1'b0;
            cnt_reg   <= '0;
            hcnt_reg  <= '0;
            good_reg  <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg <= WAIT_EDGE;
               end
               WAIT_EDGE: begin
                  if (re) begin
                     cnt_reg   <= CNT_W'(1);
                     hcnt_reg  <= CNT_W'(1);
                     good_reg  <= '0;
                     state_reg <= MEASURE;
                  end else begin
                     cnt_reg  <= cnt_next;
                     hcnt_reg <= hcnt_next;
                     if (to_hit) o_timeout <= 1'b1;
                  end
               end
               MEASURE, LOCKED: begin
                  if (re) begin
                     cnt_reg  <= CNT_W'(1);
                     hcnt_reg <= CNT_W'(1);
                     o_period <= cnt_reg;
                     o_high   <= hcnt_reg;
                     o_valid  <= 1'b1;
                     if (in_tol) begin
                        if (state_reg == MEASURE) begin
                           good_reg <= good_next;
                           if (good_next == LOCK_X) begin
                              state_reg <= LOCKED;
                              o_lock    <= 1'b1;
                           end
                        end
                     end else begin
                        o_err     <= 1'b1;
                        o_lock    <= 1'b0;
                        good_reg  <= '0;
                        state_reg <= MEASURE;
                     end
                  end else begin
                     cnt_reg  <= cnt_next;
                     hcnt_reg <= hcnt_next;
                     if (to_hit) begin
                        o_timeout <= 1'b1;
                        o_lock    <= 1'b0;
                        good_reg  <= '0;
                        state_reg <= WAIT_EDGE;
                     end
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_clk_mon.sv
// Randomized scoreboard bench for clk_mon: a waveform-level model predicts
// each measurement; a monitor pops and compares on every o_valid.
module tb_clk_mon;

   localparam int CNT_W   = 16;
   localparam int SYNC    = 2;
   localparam int EXP     = 10;
   localparam int TOL     = 1;
   localparam int LOCK    = 4;
   localparam int TIMEOUT = 40;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_en  = 1'b1;
   logic             i_mon = 1'b0;
   logic             i_clr = 1'b0;
   logic [CNT_W-1:0] o_period, o_high;
   logic             o_valid, o_lock, o_err, o_timeout;

   clk_mon #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC),
      .EXP_PERIOD  (EXP),
      .TOL         (TOL),
      .LOCK_CNT    (LOCK),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en),
      .i_mon     (i_mon),
      .i_clr     (i_clr),
      .o_period  (o_period),
      .o_high    (o_high),
      .o_valid   (o_valid),
      .o_lock    (o_lock),
      .o_err     (o_err),
      .o_timeout (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
      logic             lock;
      logic             err;
      logic             to;
   } txn_t;

   txn_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_txn    = 0;
   int   cyc      = 0;
   int   last_valid_cyc = 0;
   bit   expect_to = 0;
   bit   to_seen   = 0;

   // Reference model state, expressed on the waveform the bench generates.
   int   prev_p, prev_h, last_period;
   bit   have_prev;
   int   good_run;
   bit   m_lock, m_err, m_to;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   task automatic model_reset();
      have_prev = 0; good_run = 0; m_lock = 0; m_err = 0; m_to = 0;
   endtask

   // Called at each generated rising edge: closes the previous period.
   task automatic model_edge();
      txn_t t;
      if (have_prev) begin
         if (prev_p >= EXP - TOL && prev_p <= EXP + TOL) begin
            good_run++;
            if (good_run >= LOCK) m_lock = 1;
         end else begin
            good_run = 0; m_lock = 0; m_err = 1;
         end
         t.period = CNT_W'(prev_p);
         t.high   = CNT_W'(prev_h);
         t.lock   = m_lock;
         t.err    = m_err;
         t.to     = m_to;
         exp_q.push_back(t);
         last_period = prev_p;
      end
   endtask

   // One period of i_mon: h cycles high then p-h low, starting at a rising edge.
   task automatic run_period(input int p, input int h, input bit clr_hit, input bit clr_end);
      model_edge();
      prev_p = p; prev_h = h; have_prev = 1;
      for (int c = 0; c < p; c++) begin
         i_mon = (c < h);
         i_clr = (clr_hit && (c == 2 || c == 3)) || (clr_end && c == p - 1);
         if (clr_hit && c == 3) check("err_clr_same_cycle", o_err, 1);
         if (clr_hit && c == 4) check("err_clr_next_cycle", o_err, 0);
         @(negedge i_clk);
      end
      i_clr = 1'b0;
      if (clr_hit || clr_end) begin
         m_err = 0; m_to = 0;
      end
   endtask

   task automatic monitor();
      txn_t a, e;
      bit   prev_to = 0;
      forever begin
         @(posedge i_clk);
         #1;
         cyc++;
         if (o_valid) begin
            last_valid_cyc = cyc;
            a = {o_period, o_high, o_lock, o_err, o_timeout};
            n_txn++;
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               n_checks++;
               if (a == e) begin
                  n_pass++;
                  $display("txn %0d: period=%0d high=%0d lock=%0d err=%0d to=%0d ok",
                           n_txn, a.period, a.high, a.lock, a.err, a.to);
               end else begin
                  $display("FAIL txn %0d: got p=%0d h=%0d l=%0d e=%0d t=%0d, required p=%0d h=%0d l=%0d e=%0d t=%0d",
                           n_txn, a.period, a.high, a.lock, a.err, a.to,
                           e.period, e.high, e.lock, e.err, e.to);
               end
            end
         end
         if (o_timeout && !prev_to) begin
            to_seen = 1;
            check("timeout_expected", expect_to, 1);
            check("timeout_delay", cyc - last_valid_cyc, TIMEOUT);
            check("timeout_lock", o_lock, 0);
         end
         prev_to = o_timeout;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, h, k;
      bit ce;
      model_reset();
      fork
         monitor();
      join_none

      #3;
      check("reset_outputs", {o_period, o_high, o_valid, o_lock, o_err, o_timeout}, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (3) @(negedge i_clk);

      // Clean divide-by-10: lock on the 4th measurement.
      repeat (6) run_period(10, 5, 0, 0);
      // Long period while locked: error and unlock, relock with err still sticky.
      run_period(12, 6, 0, 0);
      repeat (5) run_period(10, 2, 0, 0);
      // Bad period whose edge coincides with i_clr: error wins, then clears.
      run_period(12, 6, 0, 0);
      run_period(10, 5, 1, 0);
      repeat (5) run_period(10, 5, 0, 0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) != 0) begin
            p = $urandom_range(EXP + TOL, EXP - TOL);
         end else begin
            k = $urandom_range(0, 5);
            p = (k < 3) ? 6 + k : 9 + k;
         end
         h  = $urandom_range(1, p - 1);
         ce = ($urandom_range(0, 7) == 0);
         run_period(p, h, 0, ce);
      end

      // Drop enable while locked.
      repeat (6) run_period(10, 5, 0, 0);
      check("lock_before_en_drop", o_lock, 1);
      i_en = 1'b0;
      @(negedge i_clk);
      check("en_drop_lock", o_lock, 0);
      check("en_drop_period_hold", o_period, last_period);
      have_prev = 0; good_run = 0; m_lock = 0;
      repeat (3) @(negedge i_clk);
      i_en = 1'b1;
      repeat (3) @(negedge i_clk);

      // Stall i_mon high while locked.
      repeat (6) run_period(10, 5, 0, 0);
      model_edge();
      expect_to = 1; to_seen = 0;
      i_mon = 1'b1;
      repeat (TIMEOUT + 10) @(negedge i_clk);
      i_mon = 1'b0;
      repeat (3) @(negedge i_clk);
      check("timeout_seen", to_seen, 1);
      check("timeout_sticky", o_timeout, 1);
      expect_to = 0;
      m_to = 1; m_lock = 0; good_run = 0; have_prev = 0;
      repeat (3) run_period(10, 5, 0, 0);
      run_period(10, 5, 0, 1);
      check("timeout_cleared", o_timeout, 0);

      // Asynchronous reset in the middle of a period.
      repeat (3) run_period(10, 5, 0, 0);
      @(posedge i_clk);
      #2 i_rst = 1'b1;
      #1 check("midrun_reset_outputs", {o_period, o_high, o_valid, o_lock, o_err, o_timeout}, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      model_reset();
      repeat (3) @(negedge i_clk);
      repeat (6) run_period(9, 4, 0, 0);

      repeat (20) @(negedge i_clk);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
